td4_fetch_decode: RTL and testbench
===================================

// Module: td4_fetch_decode
// PURPOSE
//  Program-memory and control front end for the TD4 register/ALU datapath.
//  - Holds a writable 16x8 program memory indexed by the datapath's ADDR_ROM.
//  - Decodes the addressed word into LOAD_N, SELECT and IMMED for the datapath.
//  - A run/halt/step FSM gates execution; the memory is loaded only while halted.
// PARAMETERS
//  CNT_W  16  width of the executed-instruction counter INSTR_COUNT
// PORTS
//  CLK          in   1      system clock, rising edge
//  CLR          in   1      asynchronous reset, active-high
//  ADDR_ROM     in   4      PC from the datapath; program memory read address
//  CARRY_N      in   1      registered carry flag from the datapath (active-low)
//  START        in   1      pulse: HALT -> RUN
//  STOP         in   1      pulse: RUN -> HALT
//  STEP         in   1      pulse: execute exactly one instruction from HALT
//  LD_VALID     in   1      program-write request
//  LD_ADDR      in   4      program-write address
//  LD_DATA      in   8      program-write data {opcode[7:4], imm[3:0]}
//  LD_READY     out  1      write accepted when LD_VALID & LD_READY (high in HALT only)
//  EXEC         out  1      datapath clock enable; instruction retires on edges with EXEC=1
//  LOAD_N       out  4      register load strobes {PC,OUT,B,A}, active-low
//  SELECT       out  2      source mux: 00=A 01=B 10=IN 11=zero
//  IMMED        out  4      mem[ADDR_ROM][3:0]
//  STATE        out  2      00=HALT 01=RUN 10=STEP
//  INSTR_COUNT  out  CNT_W  count of cycles with EXEC=1; saturates at all-ones
// BEHAVIOUR
//  Reset: STATE=HALT; all mem words=8'h00; INSTR_COUNT=0.
//   Outputs at reset: EXEC=0, LOAD_N=4'b1111, LD_READY=1, SELECT=00, IMMED=0.
//  FSM, all transitions registered; effect visible the cycle after the request:
//  - HALT: START -> RUN. Else STEP -> STEP (START wins over STEP).
//  - HALT: START and STOP together -> stay HALT (STOP wins).
//  - RUN:  STOP -> HALT. STEP and START are ignored.
//  - STEP: lasts exactly one cycle, then HALT. START, STOP and STEP are ignored.
//  EXEC = (STATE==RUN)|(STATE==STEP), combinational from the state register.
//  Load: on a rising edge with LD_VALID & LD_READY, mem[LD_ADDR] <= LD_DATA.
//   A write in the same cycle as START still completes.
//   LD_VALID outside HALT is dropped and memory is unchanged.
//  Decode is combinational from w = mem[ADDR_ROM], zero-cycle latency:
//   op  SEL LOAD_N     op  SEL LOAD_N     op  SEL LOAD_N
//   0000 00 1110       0001 01 1110       0010 10 1110
//   0011 11 1110       0100 00 1101       0101 01 1101
//   0110 10 1101       0111 11 1101       1001 01 1011
//   1011 11 1011       1111 11 0111
//   1110 11 0111 if CARRY_N=1, else 1111
//   1000/1010/1100/1101: undefined, treated as NOP: SEL=00, LOAD_N=1111
//  SELECT and IMMED always follow the decode. LOAD_N is forced to 4'b1111 when EXEC=0.
//  INSTR_COUNT increments on every edge where EXEC=1 and holds at 2^CNT_W-1.
//  Reset mid-RUN aborts immediately.
//   The program is lost; the datapath is reset by the same CLR.
// CONFIGURATION
//  TD4_BREAKPOINT_EN defined: adds input BP_ENABLE (1) and input BP_ADDR (4).
//  - In RUN, if BP_ENABLE & (ADDR_ROM==BP_ADDR):
//    EXEC is forced low that same cycle and the next state is HALT.
//  - The breakpoint is suppressed on the first RUN cycle after START.
//    This lets a resume proceed from the breakpoint address.
//  - STEP is never blocked by the breakpoint.
//  Undefined: the ports are absent and RUN continues until STOP.
// TESTING
//  1 Assert CLR -> STATE=00, EXEC=0, LOAD_N=1111, LD_READY=1, INSTR_COUNT=0.
//  2 Load mem[0]=8'h35, ADDR_ROM=0, halted -> SELECT=11, IMMED=5, LOAD_N=1111.
//    Then START -> next cycle LOAD_N=1110, EXEC=1.
//  3 mem[0]=8'hE7 in RUN: CARRY_N=1 -> LOAD_N=0111; CARRY_N=0 -> LOAD_N=1111.
//    Both cases: IMMED=7.
//  4 STEP pulse in HALT -> EXEC=1 for exactly one cycle; INSTR_COUNT 0->1.
//    LD_READY=0 during that cycle, then STATE returns to HALT.
//  5 START+STOP in the same cycle -> stays HALT.
//    In RUN, LD_VALID with LD_DATA=8'hFF to addr 2 -> mem[2] unchanged.
//    STOP -> EXEC=0 next cycle.
//  6 TD4_BREAKPOINT_EN, BP_ADDR=3, counting PC from 0 -> EXEC=0 when ADDR_ROM=3.
//    Result: INSTR_COUNT=3, STATE=HALT. Re-START retires the instruction at addr 3.

Source files
------------

// File: rtl/td4_fetch_decode.sv
// TD4 program memory, instruction decode and run/halt/step control; TD4_BREAKPOINT_EN adds a PC breakpoint.
// Latency: decode is combinational from addr_rom; state changes land one cycle after a start/stop/step pulse.
// Backpressure: ld_ready is high only in HALT; loads offered while running are dropped.
module td4_fetch_decode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       addr_rom,
  input  logic             carry_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             ld_valid,
  input  logic [3:0]       ld_addr,
  input  logic [7:0]       ld_data,
`ifdef TD4_BREAKPOINT_EN
  input  logic             bp_enable,
  input  logic [3:0]       bp_addr,
`endif
  output logic             ld_ready,
  output logic             exec,
  output logic [3:0]       load_n,
  output logic [1:0]       select,
  output logic [3:0]       immed,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] load_n;
    logic [1:0] sel;
  } dec_t;

  state_t           st;
  logic [7:0]       mem [16];
  logic [CNT_W-1:0] cnt;
  logic [7:0]       word;
  dec_t             dec;
  logic             bp_hit;

`ifdef TD4_BREAKPOINT_EN
  // High for the first RUN cycle after START so a resume can leave the breakpoint address.
  logic first_run;
  assign bp_hit = (st == RUN) && bp_enable && (addr_rom == bp_addr) && !first_run;
`else
  assign bp_hit = 1'b0;
`endif

  assign word        = mem[addr_rom];
  assign ld_ready    = (st == HALT);
  assign exec        = ((st == RUN) && !bp_hit) || (st == STEP);
  assign state       = st;
  assign instr_count = cnt;
  assign select      = dec.sel;
  assign immed       = word[3:0];
  assign load_n      = exec ? dec.load_n : 4'b1111;

  always_comb begin
    dec = '{load_n: 4'b1111, sel: 2'b00};
    case (word[7:4])
      4'b0000: dec = '{load_n: 4'b1110, sel: 2'b00};
      4'b0001: dec = '{load_n: 4'b1110, sel: 2'b01};
      4'b0010: dec = '{load_n: 4'b1110, sel: 2'b10};
      4'b0011: dec = '{load_n: 4'b1110, sel: 2'b11};
      4'b0100: dec = '{load_n: 4'b1101, sel: 2'b00};
      4'b0101: dec = '{load_n: 4'b1101, sel: 2'b01};
      4'b0110: dec = '{load_n: 4'b1101, sel: 2'b10};
      4'b0111: dec = '{load_n: 4'b1101, sel: 2'b11};
      4'b1001: dec = '{load_n: 4'b1011, sel: 2'b01};
      4'b1011: dec = '{load_n: 4'b1011, sel: 2'b11};
      4'b1110: dec = '{load_n: (carry_n ? 4'b0111 : 4'b1111), sel: 2'b11};
      4'b1111: dec = '{load_n: 4'b0111, sel: 2'b11};
      default: dec = '{load_n: 4'b1111, sel: 2'b00};
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st  <= HALT;
      cnt <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
`ifdef TD4_BREAKPOINT_EN
      first_run <= 1'b0;
`endif
    end else begin
      if (ld_valid && ld_ready) mem[ld_addr] <= ld_data;
      if (exec && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
`ifdef TD4_BREAKPOINT_EN
      first_run <= (st == HALT) && start && !stop;
`endif
      case (st)
        HALT: begin
          if (start) begin
            if (!stop) st <= RUN;
          end else if (step) begin
            st <= STEP;
          end
        end
        RUN:     if (stop || bp_hit) st <= HALT;
        STEP:    st <= HALT;
        default: st <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_fetch_decode.sv
// Directed bench for td4_fetch_decode; expectations are queued by the stimulus and checked by a negedge monitor.
module tb_td4_fetch_decode;

  localparam int W = 4;
  localparam int F_STATE = 0, F_EXEC = 1, F_LDN = 2, F_SEL = 3, F_IMM = 4, F_RDY = 5, F_CNT = 6;

  logic         clk = 1'b0;
  logic         clr;
  logic [3:0]   addr_rom;
  logic         carry_n, start, stop, step, ld_valid;
  logic [3:0]   ld_addr;
  logic [7:0]   ld_data;
  logic         ld_ready, exec;
  logic [3:0]   load_n, immed;
  logic [1:0]   select, state;
  logic [W-1:0] instr_count;
`ifdef TD4_BREAKPOINT_EN
  logic         bp_enable;
  logic [3:0]   bp_addr;
`endif

  int          total = 0;
  int          bad   = 0;
  int          fld_q[$];
  logic [31:0] val_q[$];
  string       nm_q[$];

  always #5 clk = ~clk;

  td4_fetch_decode #(.CNT_W(W)) dut (
    .clk(clk), .clr(clr), .addr_rom(addr_rom), .carry_n(carry_n),
    .start(start), .stop(stop), .step(step),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef TD4_BREAKPOINT_EN
    .bp_enable(bp_enable), .bp_addr(bp_addr),
`endif
    .ld_ready(ld_ready), .exec(exec), .load_n(load_n), .select(select),
    .immed(immed), .state(state), .instr_count(instr_count)
  );

  function automatic logic [31:0] actual(int f);
    case (f)
      F_STATE: return {30'd0, state};
      F_EXEC:  return {31'd0, exec};
      F_LDN:   return {28'd0, load_n};
      F_SEL:   return {30'd0, select};
      F_IMM:   return {28'd0, immed};
      F_RDY:   return {31'd0, ld_ready};
      default: return {{(32-W){1'b0}}, instr_count};
    endcase
  endfunction

  always @(negedge clk) begin
    while (fld_q.size() > 0) begin
      int          f;
      logic [31:0] v, a;
      string       n;
      f = fld_q.pop_front();
      v = val_q.pop_front();
      n = nm_q.pop_front();
      a = actual(f);
      total++;
      if (a !== v) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h at %0t", n, a, v, $time);
      end
    end
  end

  task automatic ex(input int f, input logic [31:0] v, input string n);
    fld_q.push_back(f);
    val_q.push_back(v);
    nm_q.push_back(n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    cyc();
    ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; addr_rom = 4'd0; carry_n = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 8'd0;
`ifdef TD4_BREAKPOINT_EN
    bp_enable = 1'b0; bp_addr = 4'd0;
`endif
    #1;
    ex(F_STATE, 0, "rst_state"); ex(F_EXEC, 0, "rst_exec"); ex(F_LDN, 4'hF, "rst_load_n");
    ex(F_RDY, 1, "rst_ld_ready"); ex(F_CNT, 0, "rst_count"); ex(F_SEL, 0, "rst_select");
    ex(F_IMM, 0, "rst_immed");
    cyc(); cyc();
    clr = 1'b0;

    // Halted decode of 8'h35 keeps strobes off; START enables them next cycle.
    wr(4'd0, 8'h35);
    ex(F_SEL, 3, "h35_select"); ex(F_IMM, 5, "h35_immed"); ex(F_LDN, 4'hF, "h35_halt_load_n");
    ex(F_EXEC, 0, "h35_halt_exec");
    start = 1'b1; cyc(); start = 1'b0;
    ex(F_LDN, 4'hE, "h35_run_load_n"); ex(F_EXEC, 1, "h35_run_exec"); ex(F_STATE, 1, "run_state");
    ex(F_CNT, 0, "run_first_count"); ex(F_RDY, 0, "run_ld_ready");
    stop = 1'b1; cyc(); stop = 1'b0;
    ex(F_STATE, 0, "stop_state"); ex(F_CNT, 1, "stop_count");

    // Conditional jump on carry.
    wr(4'd0, 8'hE7);
    carry_n = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    ex(F_LDN, 4'h7, "jnc_taken_load_n"); ex(F_IMM, 7, "jnc_taken_immed"); ex(F_SEL, 3, "jnc_select");
    ex(F_CNT, 1, "jnc_count");
    cyc();
    carry_n = 1'b0;
    ex(F_LDN, 4'hF, "jnc_not_taken_load_n"); ex(F_IMM, 7, "jnc_not_taken_immed");
    ex(F_EXEC, 1, "jnc_exec"); ex(F_CNT, 2, "jnc_count2");
    stop = 1'b1; cyc(); stop = 1'b0; carry_n = 1'b1;
    ex(F_STATE, 0, "halt_state"); ex(F_EXEC, 0, "halt_exec"); ex(F_CNT, 3, "halt_count");
    ex(F_LDN, 4'hF, "halt_load_n");

    // Single step; START/STEP during the step cycle are ignored.
    step = 1'b1; cyc(); step = 1'b0;
    ex(F_STATE, 2, "step_state"); ex(F_EXEC, 1, "step_exec"); ex(F_RDY, 0, "step_ld_ready");
    ex(F_LDN, 4'h7, "step_load_n"); ex(F_CNT, 3, "step_count_before");
    start = 1'b1; step = 1'b1; cyc(); start = 1'b0; step = 1'b0;
    ex(F_STATE, 0, "step_return_state"); ex(F_EXEC, 0, "step_return_exec");
    ex(F_CNT, 4, "step_count_after"); ex(F_RDY, 1, "step_return_ld_ready");

    // START+STOP together stays halted; loads while running are dropped.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    ex(F_STATE, 0, "start_stop_state"); ex(F_CNT, 4, "start_stop_count");
    start = 1'b1; cyc(); start = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd2; ld_data = 8'hFF; step = 1'b1;
    ex(F_RDY, 0, "run_drop_ld_ready"); ex(F_STATE, 1, "run_state2");
    cyc(); ld_valid = 1'b0; step = 1'b0; addr_rom = 4'd2;
    ex(F_STATE, 1, "run_step_ignored"); ex(F_IMM, 0, "dropped_immed"); ex(F_SEL, 0, "dropped_select");
    ex(F_LDN, 4'hE, "dropped_load_n");
    stop = 1'b1; cyc(); stop = 1'b0;
    ex(F_EXEC, 0, "stop2_exec"); ex(F_STATE, 0, "stop2_state"); ex(F_CNT, 6, "stop2_count");
    ex(F_IMM, 0, "mem2_unchanged");

    // A load issued alongside START still lands.
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 8'h9A; start = 1'b1;
    cyc(); ld_valid = 1'b0; start = 1'b0; addr_rom = 4'd1;
    ex(F_SEL, 1, "h9a_select"); ex(F_LDN, 4'hB, "h9a_load_n"); ex(F_IMM, 4'hA, "h9a_immed");
    ex(F_STATE, 1, "h9a_state");
    stop = 1'b1; cyc(); stop = 1'b0;

    // Undefined opcode acts as NOP; counter saturates.
    wr(4'd3, 8'hC5);
    addr_rom = 4'd3; start = 1'b1; cyc(); start = 1'b0;
    ex(F_SEL, 0, "nop_select"); ex(F_LDN, 4'hF, "nop_load_n"); ex(F_IMM, 5, "nop_immed");
    ex(F_EXEC, 1, "nop_exec"); ex(F_CNT, 7, "nop_count");
    repeat (10) cyc();
    ex(F_CNT, 15, "sat_count_run");
    stop = 1'b1; cyc(); stop = 1'b0;
    ex(F_CNT, 15, "sat_count_halt"); ex(F_STATE, 0, "sat_state");

    // Reset while running aborts and clears the program.
    start = 1'b1; cyc(); start = 1'b0;
    ex(F_STATE, 1, "pre_reset_state");
    cyc();
    clr = 1'b1;
    ex(F_STATE, 0, "midrun_rst_state"); ex(F_EXEC, 0, "midrun_rst_exec");
    ex(F_CNT, 0, "midrun_rst_count"); ex(F_IMM, 0, "midrun_rst_immed");
    ex(F_RDY, 1, "midrun_rst_ld_ready");
    cyc(); clr = 1'b0;

`ifdef TD4_BREAKPOINT_EN
    bp_addr = 4'd3; bp_enable = 1'b1; addr_rom = 4'd0;
    start = 1'b1; cyc(); start = 1'b0;
    ex(F_EXEC, 1, "bp_pc0_exec");
    cyc(); addr_rom = 4'd1;
    ex(F_EXEC, 1, "bp_pc1_exec");
    cyc(); addr_rom = 4'd2;
    cyc(); addr_rom = 4'd3;
    ex(F_EXEC, 0, "bp_hit_exec"); ex(F_LDN, 4'hF, "bp_hit_load_n");
    ex(F_CNT, 3, "bp_hit_count"); ex(F_STATE, 1, "bp_hit_state");
    cyc();
    ex(F_STATE, 0, "bp_halt_state"); ex(F_CNT, 3, "bp_halt_count");
    start = 1'b1; cyc(); start = 1'b0;
    ex(F_EXEC, 1, "bp_resume_exec"); ex(F_STATE, 1, "bp_resume_state");
    cyc(); addr_rom = 4'd4;
    ex(F_CNT, 4, "bp_resume_count"); ex(F_EXEC, 1, "bp_pc4_exec");
    stop = 1'b1; cyc(); stop = 1'b0;
`endif

    cyc(); cyc();
    if (fld_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", fld_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
